// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared types and encodings for the multicycle RISC-V controller:
//   state_e      - controller FSM states
//   alu_ctrl_e   - ALU operation codes driven on alu_ctrl_o
//   alu_class_e  - which decode rule the ALU decoder applies in a state
//   OP_*         - opcode field values the controller dispatches on
//   SRC_A_*, SRC_B_*, RES_* - datapath mux select encodings
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_ctrl_e;

    // Address/branch-target/PC+4 states always add; BRANCH always subtracts;
    // EXECR and EXECI decode funct3/funct7b5 with slightly different rules.
    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_SUB = 2'd1,
        CLS_R   = 2'd2,
        CLS_I   = 2'd3
    } alu_class_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_OLDPC = 2'd1;
    localparam logic [1:0] SRC_A_RS1   = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_IMM  = 2'd1;
    localparam logic [1:0] SRC_B_FOUR = 2'd2;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_MEMDATA   = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Memory request handshake between the controller (master) and memory (slave).
//   mem_req_o   - controller requests a transfer; held high until accepted
//   mem_we_o    - write qualifier, meaningful only while mem_req_o = 1
//   mem_ready_i - memory accepts the request / returns data this cycle
// Handshake: a transfer completes on a rising edge where mem_req_o and
// mem_ready_i are both 1. mem_req_o and mem_we_o do not change while a request
// is pending; mem_ready_i while mem_req_o = 0 is ignored. Reset drops
// mem_req_o immediately, abandoning any pending request.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_we_o;
    logic mem_ready_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        input  mem_ready_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        output mem_ready_i
    );
endinterface

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode.
//   cls_i      - decode rule selected by the controller state
//   funct3_i   - instr[14:12]
//   funct7b5_i - instr[30]
//   alu_ctrl_o - ALU operation
// ---------------------------------------------------------------------------
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_e cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output alu_ctrl_e  alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (cls_i)
            CLS_SUB: alu_ctrl_o = ALU_SUB;
            CLS_R, CLS_I: begin
                case (funct3_i)
                    // Immediate forms have no subtract; bit 30 is part of the immediate.
                    3'b000:  alu_ctrl_o = (cls_i == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl_o = ALU_SLL;
                    3'b010:  alu_ctrl_o = ALU_SLT;
                    // No unsigned compare in this ALU; SLTU falls back to SLT.
                    3'b011:  alu_ctrl_o = ALU_SLT;
                    3'b100:  alu_ctrl_o = ALU_XOR;
                    3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl_o = ALU_OR;
                    default: alu_ctrl_o = ALU_AND;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle RV32 subset (load/store, OP, OP-IMM, BEQ/BNE,
// JAL). Unsupported instructions park the FSM in TRAP until reset.
//   clk_i, rst_ni          - clock, asynchronous active-low reset
//   opcode_i, funct3_i,
//   funct7b5_i             - fields of the held instruction register
//   zero_i                 - ALU zero flag (branch compare)
//   mem                    - memory handshake (multicycle_ctrl_if.master)
//   adr_src_o              - memory address: 0 = PC, 1 = ALUOut
//   alu_src_a_o/_b_o       - ALU operand selects
//   alu_ctrl_o             - ALU operation
//   result_src_o           - writeback select
//   ir_write_o, pc_write_o,
//   reg_write_o            - write strobes
//   illegal_o              - sticky unsupported-instruction flag
//   instret_o              - retired instruction count (wraps)
//   state_o                - current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [6:0]               opcode_i,
    input  logic [2:0]               funct3_i,
    input  logic                     funct7b5_i,
    input  logic                     zero_i,
    multicycle_ctrl_if.master        mem,
    output logic                     adr_src_o,
    output logic [1:0]               alu_src_a_o,
    output logic [1:0]               alu_src_b_o,
    output logic [3:0]               alu_ctrl_o,
    output logic [1:0]               result_src_o,
    output logic                     ir_write_o,
    output logic                     pc_write_o,
    output logic                     reg_write_o,
    output logic                     illegal_o,
    output logic [31:0]              instret_o,
    output logic [3:0]               state_o
);

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [31:0] instret_q, instret_d;

    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        retire;
    alu_class_e  alu_cls;
    alu_ctrl_e   alu_op;

    assign mem_ready     = mem.mem_ready_i;
    assign mem.mem_req_o = mem_req;
    assign mem.mem_we_o  = mem_we;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3_i == F3_BEQ || funct3_i == F3_BNE)
                                                 ? S_BRANCH : S_TRAP;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            // Only loads and stores reach MEMADR, so a non-store is a load.
            S_MEMADR: state_d = (opcode_i == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_MEMWB:  state_d = S_FETCH;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JAL:    state_d = S_ALUWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from its last
    // state; JAL is counted once, when its ALUWB completes.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_MEMWR:                   retire = mem_ready;
            S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
            default:                   retire = 1'b0;
        endcase
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;
    // Set on entry so illegal_o is already high in the first TRAP cycle.
    assign illegal_d = illegal_q | (state_d == S_TRAP);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except FETCH strobes and BRANCH pc_write)
    // ------------------------------------------------------------------
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = SRC_A_PC;
        alu_src_b_o  = SRC_B_RS2;
        result_src_o = RES_ALUOUT;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        alu_cls      = CLS_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_a_o = SRC_A_PC;
                alu_src_b_o = SRC_B_FOUR;
                // IR and PC+4 are captured only on the accepting edge.
                ir_write_o  = mem_ready;
                pc_write_o  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a_o = SRC_A_OLDPC;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMADR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
            end
            S_MEMRD: begin
                mem_req   = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                adr_src_o = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                result_src_o = RES_MEMDATA;
            end
            S_EXECR: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_RS2;
                alu_cls     = CLS_R;
            end
            S_EXECI: begin
                alu_src_a_o = SRC_A_RS1;
                alu_src_b_o = SRC_B_IMM;
                alu_cls     = CLS_I;
            end
            S_ALUWB: begin
                reg_write_o  = 1'b1;
                result_src_o = RES_ALUOUT;
            end
            S_BRANCH: begin
                alu_src_a_o  = SRC_A_RS1;
                alu_src_b_o  = SRC_B_RS2;
                alu_cls      = CLS_SUB;
                result_src_o = RES_ALUOUT;
                // DECODE only lets BEQ/BNE through, so bit 0 picks the sense.
                pc_write_o   = funct3_i[0] ? ~zero_i : zero_i;
            end
            S_JAL: begin
                alu_src_a_o  = SRC_A_OLDPC;
                alu_src_b_o  = SRC_B_FOUR;
                pc_write_o   = 1'b1;
                result_src_o = RES_ALUOUT;
            end
            default: begin
                // IDLE and TRAP drive everything low.
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .cls_i      (alu_cls),
        .funct3_i   (funct3_i),
        .funct7b5_i (funct7b5_i),
        .alu_ctrl_o (alu_op)
    );

    // ALU op only matters in states that use the ALU; elsewhere it is ADD (0).
    assign alu_ctrl_o = alu_op;
    assign illegal_o  = illegal_q;
    assign instret_o  = instret_q;
    assign state_o    = state_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have rst_ni, input, 1, asynchronous active-low reset.
REQ-003 SHALL have opcode_i, input, 7, opcode field of the held instruction register.
REQ-004 SHALL have funct3_i, input, 3, instr[14:12].
REQ-005 SHALL have funct7b5_i, input, 1, instr[30].
REQ-006 SHALL have zero_i, input, 1, ALU zero flag.
REQ-007 SHALL have mem_ready_i, input, 1, memory accepts the request or returns data this cycle.
REQ-008 SHALL have mem_req_o, output, 1, memory request; held until mem_ready_i.
REQ-009 SHALL have mem_we_o, output, 1, write qualifier for mem_req_o.
REQ-010 SHALL have adr_src_o, output, 1, memory address select: 0 = PC, 1 = ALUOut.
REQ-011 SHALL have alu_src_a_o, output, 2, ALU A select: 0 = PC, 1 = oldPC, 2 = rs1.
REQ-012 SHALL have alu_src_b_o, output, 2, ALU B select, driving the existing operand mux: 0 = rs2, 1 = immediate, 2 = constant 4.
REQ-013 SHALL have alu_ctrl_o, output, 4, ALU op: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8.
REQ-014 SHALL have result_src_o, output, 2, writeback select: 0 = ALUOut, 1 = memory data, 2 = ALU result.
REQ-015 SHALL have ir_write_o, pc_write_o, reg_write_o, outputs, 1 each, write strobes.
REQ-016 SHALL have illegal_o, output, 1, sticky unsupported-instruction flag.
REQ-017 SHALL have instret_o, output, 32, count of retired instructions.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
REQ-019 IDLE SHALL drive all outputs 0 and move to FETCH unconditionally on the next edge.
REQ-020 FETCH SHALL assert mem_req_o with adr_src_o = 0, src_a = 0, src_b = 2, ADD; it SHALL stall while mem_ready_i = 0; with mem_ready_i = 1 it SHALL pulse ir_write_o and pc_write_o for one cycle and go to DECODE.
REQ-021 DECODE SHALL compute the branch target (src_a = 1, src_b = 1, ADD) and dispatch on opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL, anything else -> TRAP.
REQ-022 DECODE SHALL also dispatch to TRAP when the opcode is 1100011 and funct3 is not 000 or 001.
REQ-023 MEMADR SHALL use src_a = 2, src_b = 1, ADD, then go to MEMRD for a load or MEMWR for a store.
REQ-024 MEMRD and MEMWR SHALL assert mem_req_o with adr_src_o = 1 (mem_we_o = 1 in MEMWR only) and stall until mem_ready_i; MEMRD then goes to MEMWB, and MEMWR goes to FETCH.
REQ-025 MEMWB SHALL assert reg_write_o with result_src_o = 1, then go to FETCH.
REQ-026 EXECR SHALL use src_a = 2, src_b = 0, with ALU op from funct3: 000 gives ADD, or SUB if funct7b5 = 1.
REQ-027 EXECI SHALL use src_a = 2, src_b = 1; SUB SHALL never be issued, and funct3 101 with funct7b5 = 1 SHALL give SRA.
REQ-028 EXECR and EXECI SHALL go to ALUWB; ALUWB SHALL assert reg_write_o with result_src_o = 0, then go to FETCH.
REQ-029 BRANCH SHALL use src_a = 2, src_b = 0, SUB, result_src_o = 0; pc_write_o SHALL equal zero_i for funct3 000 and !zero_i for funct3 001; then go to FETCH.
REQ-030 JAL SHALL use src_a = 1, src_b = 2, ADD, assert pc_write_o with result_src_o = 0, then go to ALUWB.
REQ-031 TRAP SHALL be absorbing until reset, set illegal_o = 1, and drive all strobes and mem_req_o to 0.
REQ-032 instret_o SHALL increment by 1 on each transition into FETCH from MEMWR, MEMWB, ALUWB or BRANCH, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-033 All outputs except instret_o and illegal_o SHALL be Moore decodes of state, except that pc_write_o in BRANCH and the handshake-qualified strobes in FETCH also depend on inputs; unlisted selects SHALL be 0.

Reset
REQ-034 While rst_ni = 0, state SHALL be IDLE, instret_o = 0, illegal_o = 0 and all outputs 0; an assertion mid-transaction SHALL drop mem_req_o immediately without waiting for mem_ready_i.

Structure
REQ-035 Package riscv_ctrl_pkg SHALL hold the state enum, opcode constants, the alu_ctrl enum, and the src_a/src_b/result_src encodings.
REQ-036 A combinational sub-module alu_decoder SHALL map (state class, funct3, funct7b5) to alu_ctrl_o.

Verification
REQ-037 Reset release with mem_ready_i = 0 for 3 cycles SHALL give IDLE, then mem_req_o = 1 held for 3 cycles, then single ir_write_o/pc_write_o pulses on ready.
REQ-038 R-type sub (opcode 0110011, funct3 000, funct7b5 1) SHALL give alu_ctrl_o = 1, src_b = 0, reg_write_o in ALUWB, and instret_o = 1.
REQ-039 Load with mem_ready_i = 1 every cycle SHALL take 5 states from FETCH, with mem_req_o = 1 twice and reg_write_o with result_src_o = 1.
REQ-040 BNE (funct3 001) with zero_i = 1 SHALL give pc_write_o = 0 in BRANCH; with zero_i = 0 it SHALL give pc_write_o = 1.
REQ-041 Opcode 1110011 SHALL enter TRAP with illegal_o = 1 and mem_req_o = 0 for 10 cycles; a reset SHALL then clear illegal_o.
REQ-042 instret_o preloaded through a hierarchical force to 0xFFFFFFFF SHALL read 0 after one more ALU instruction.
